// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// Each port gets one request per grant and a 1-deep result buffer.
module alu_share_arbiter #(
    parameter int             WIDTH      = 32,
    parameter int             SEL_W      = 4,
    parameter bit             FIXED_PRIO = 1'b0,
    parameter logic [SEL_W-1:0] IDLE_SEL = 4'hD
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e rr_ptr;
    logic  elig0, elig1;
    logic  grant0, grant1;

    // A full buffer that is being drained this cycle can take a new result.
    assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset) begin
            if (elig0 && elig1) begin
                if (FIXED_PRIO || rr_ptr == PORT0) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_sel = IDLE_SEL;
        alu_a   = '0;
        alu_b   = '0;
        if (grant0) begin
            alu_sel = req0_sel;
            alu_a   = req0_a;
            alu_b   = req0_b;
        end else if (grant1) begin
            alu_sel = req1_sel;
            alu_a   = req1_a;
            alu_b   = req1_b;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= PORT0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            if (grant0) begin
                rr_ptr <= PORT1;
            end else if (grant1) begin
                rr_ptr <= PORT0;
            end

            if (grant0) begin
                rsp0_data  <= alu_res;
                rsp0_valid <= 1'b1;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                rsp1_data  <= alu_res;
                rsp1_valid <= 1'b1;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each driven by a bench ALU and checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]    req0_sel = '0, req1_sel = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;

    logic          rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
    logic [3:0]    rr_alu_sel;
    logic [W-1:0]  rr_alu_a, rr_alu_b, rr_alu_res, rr_rsp0_data, rr_rsp1_data;
    logic          fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic [3:0]    fp_alu_sel;
    logic [W-1:0]  fp_alu_a, fp_alu_b, fp_alu_res, fp_rsp0_data, fp_rsp1_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clock = ~clock;

    // Bench ALU: 8=ADD 9=SUB 4=XOR 1=SLL 15=JALR (sum with lsb cleared), anything else returns 0.
    function automatic logic [W-1:0] alu_f(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            4'd8:    return a + b;
            4'd9:    return a - b;
            4'd4:    return a ^ b;
            4'd1:    return a << b[4:0];
            4'd15:   return (a + b) & ~32'd1;
            default: return '0;
        endcase
    endfunction

    assign rr_alu_res = alu_f(rr_alu_sel, rr_alu_a, rr_alu_b);
    assign fp_alu_res = alu_f(fp_alu_sel, fp_alu_a, fp_alu_b);

    alu_share_arbiter #(.WIDTH(W), .SEL_W(4), .FIXED_PRIO(1'b0), .IDLE_SEL(4'hD)) dut_rr (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(rr_alu_sel), .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_res(rr_alu_res),
        .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rr_rsp0_data),
        .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rr_rsp1_data)
    );

    alu_share_arbiter #(.WIDTH(W), .SEL_W(4), .FIXED_PRIO(1'b1), .IDLE_SEL(4'hD)) dut_fp (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(fp_alu_sel), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_res(fp_alu_res),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(fp_rsp0_data),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(fp_rsp1_data)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = round-robin instance, 1 = fixed-priority instance.
    logic          m_valid [2][2];
    logic [W-1:0]  m_data  [2][2];
    logic          m_next  [2];     // which port wins a tie next (round-robin only)

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_next[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_valid[d][p] = 1'b0;
                m_data[d][p]  = '0;
            end
        end
    end

    function automatic logic [1:0] exp_gnt(input int d);
        logic e0, e1;
        e0 = req0_valid && (!m_valid[d][0] || rsp0_ready);
        e1 = req1_valid && (!m_valid[d][1] || rsp1_ready);
        if (!reset) return 2'b00;
        if (e0 && e1) return (d == 1 || m_next[d] == 1'b0) ? 2'b01 : 2'b10;
        return {e1, e0};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_next[d] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    m_valid[d][p] = 1'b0;
                    m_data[d][p]  = '0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [1:0]   g;
                logic [W-1:0] res;
                g   = exp_gnt(d);
                res = g[0] ? alu_f(req0_sel, req0_a, req0_b) :
                      g[1] ? alu_f(req1_sel, req1_a, req1_b) : '0;
                if (g[0]) begin
                    m_data[d][0] = res; m_valid[d][0] = 1'b1;
                end else if (m_valid[d][0] && rsp0_ready) begin
                    m_valid[d][0] = 1'b0;
                end
                if (g[1]) begin
                    m_data[d][1] = res; m_valid[d][1] = 1'b1;
                end else if (m_valid[d][1] && rsp1_ready) begin
                    m_valid[d][1] = 1'b0;
                end
                if (g != 2'b00) m_next[d] = g[0];
            end
        end
    end

    task automatic cmp_dut(input int d, input logic r0, input logic r1, input logic [3:0] s,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1);
        logic [1:0] g;
        g = exp_gnt(d);
        check($sformatf("m%0d req0_ready", d), W'(r0), W'(g[0]));
        check($sformatf("m%0d req1_ready", d), W'(r1), W'(g[1]));
        check($sformatf("m%0d alu_sel", d), W'(s), W'(g[0] ? req0_sel : g[1] ? req1_sel : 4'hD));
        check($sformatf("m%0d alu_a", d), a, g[0] ? req0_a : g[1] ? req1_a : '0);
        check($sformatf("m%0d alu_b", d), b, g[0] ? req0_b : g[1] ? req1_b : '0);
        check($sformatf("m%0d rsp0_valid", d), W'(v0), W'(m_valid[d][0]));
        check($sformatf("m%0d rsp0_data", d), d0, m_data[d][0]);
        check($sformatf("m%0d rsp1_valid", d), W'(v1), W'(m_valid[d][1]));
        check($sformatf("m%0d rsp1_data", d), d1, m_data[d][1]);
    endtask

    always @(negedge clock) begin
        if (started) begin
            cmp_dut(0, rr_req0_ready, rr_req1_ready, rr_alu_sel, rr_alu_a, rr_alu_b,
                    rr_rsp0_valid, rr_rsp0_data, rr_rsp1_valid, rr_rsp1_data);
            cmp_dut(1, fp_req0_ready, fp_req1_ready, fp_alu_sel, fp_alu_a, fp_alu_b,
                    fp_rsp0_valid, fp_rsp0_data, fp_rsp1_valid, fp_rsp1_data);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        started = 1'b1;
        repeat (2) step();
        check("reset rsp0_valid", W'(rr_rsp0_valid), 0);
        check("reset rsp0_data", rr_rsp0_data, 0);
        check("reset alu_sel idle", W'(rr_alu_sel), 32'hD);
        @(negedge clock);
        #2 reset = 1'b1;
        step();

        // Tie with pointer at port 0, then port 1 served next cycle.
        req0_valid = 1; req0_sel = 4'd9; req0_a = 9;     req0_b = 3;
        req1_valid = 1; req1_sel = 4'd4; req1_a = 'hF0;  req1_b = 'h0F;
        @(negedge clock);
        check("tie req0_ready", W'(rr_req0_ready), 1);
        check("tie req1_ready", W'(rr_req1_ready), 0);
        check("tie alu_a", rr_alu_a, 9);
        step();
        req0_valid = 0;
        check("sub rsp0_valid", W'(rr_rsp0_valid), 1);
        check("sub rsp0_data", rr_rsp0_data, 6);
        @(negedge clock);
        check("rr req1_ready", W'(rr_req1_ready), 1);
        check("rr alu_sel", W'(rr_alu_sel), 4);
        step();
        req1_valid = 0;
        check("xor rsp1_data", rr_rsp1_data, 32'hFF);

        // Single add on port 0.
        req0_valid = 1; req0_sel = 4'b1000; req0_a = 5; req0_b = 7;
        @(negedge clock);
        check("add req0_ready", W'(rr_req0_ready), 1);
        step();
        req0_valid = 0;
        check("add rsp0_data", rr_rsp0_data, 12);

        // Stalled rsp0 blocks port 0 but not port 1.
        rsp0_ready = 0;
        req0_valid = 1; req0_sel = 4'd8; req0_a = 1; req0_b = 1;
        req1_valid = 1; req1_sel = 4'd1; req1_a = 1; req1_b = 4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall req0_ready", W'(rr_req0_ready), 0);
            check("stall req1_ready", W'(rr_req1_ready), 1);
            step();
            check("sll rsp1_data", rr_rsp1_data, 16);
            check("stall rsp0_data", rr_rsp0_data, 12);
        end
        rsp0_ready = 1;
        @(negedge clock);
        check("drain req0_ready", W'(rr_req0_ready), 1);
        step();
        req0_valid = 0; req1_valid = 0;
        check("drain rsp0_data", rr_rsp0_data, 2);

        // Full rsp1 drained and refilled in the same cycle.
        rsp1_ready = 0;
        req1_valid = 1; req1_sel = 4'd1; req1_a = 1; req1_b = 4;
        step();
        rsp1_ready = 1;
        req1_sel = 4'd15; req1_a = 32'h1001; req1_b = 4;
        @(negedge clock);
        check("refill rsp1_valid", W'(rr_rsp1_valid), 1);
        check("refill req1_ready", W'(rr_req1_ready), 1);
        step();
        req1_valid = 0;
        check("jalr rsp1_data", rr_rsp1_data, 32'h1004);

        // Continuous contention: fixed priority starves port 1, round-robin alternates.
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_sel = 4'd8; req0_a = W'(i); req0_b = 1;
            req1_valid = 1; req1_sel = 4'd9; req1_a = 100;   req1_b = W'(i);
            @(negedge clock);
            check("fp req0_ready", W'(fp_req0_ready), 1);
            check("fp req1_ready", W'(fp_req1_ready), 0);
            check("rr alternate", W'(rr_req0_ready), W'(i % 2 == 0));
            step();
            check("fp rsp0_data", fp_rsp0_data, W'(i + 1));
        end
        req0_valid = 0;
        @(negedge clock);
        check("fp release req1", W'(fp_req1_ready), 1);
        step();
        req1_valid = 0;
        step();

        // Fill both buffers (port 0 last so the pointer sits at port 1), then reset.
        rsp0_ready = 0; rsp1_ready = 0;
        req1_valid = 1; req1_sel = 4'd8; req1_a = 3; req1_b = 4;
        step();
        req1_valid = 0;
        req0_valid = 1; req0_sel = 4'd8; req0_a = 10; req0_b = 20;
        step();
        check("full rsp0_data", rr_rsp0_data, 30);
        check("full rsp1_data", rr_rsp1_data, 7);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async rsp0_valid", W'(rr_rsp0_valid), 0);
        check("async rsp1_valid", W'(rr_rsp1_valid), 0);
        check("async rsp0_data", rr_rsp0_data, 0);
        check("async rsp1_data", rr_rsp1_data, 0);
        check("async fp rsp1_valid", W'(fp_rsp1_valid), 0);
        check("reset req0_ready", W'(rr_req0_ready), 0);
        step();
        #1 reset = 1'b1;
        rsp0_ready = 1; rsp1_ready = 1;
        req1_valid = 1; req1_sel = 4'd8; req1_a = 1; req1_b = 1;
        @(negedge clock);
        check("post-reset ptr req0", W'(rr_req0_ready), 1);
        check("post-reset ptr req1", W'(rr_req1_ready), 0);
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
